// File: rtl/cnt_share_pkg.sv
// rtl/cnt_share_pkg.sv - shared types, mode constants and bit-reverse helper for cnt_share_seq_gen
// Contents:
//   state_t   run-control FSM states (IDLE, RUN, DRAIN)
//   MODE_BIN  binary up-count sequence
//   MODE_REV  bit-reversed (low-discrepancy) sequence
//   bit_rev   reverses the low 'width' bits of a value (width <= REV_MAX)
package cnt_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_REV = 1'b1;

    localparam int REV_MAX = 32;

    // Bits at and above 'width' come back as zero, so callers can cast the
    // result straight down to their own width.
    function automatic logic [REV_MAX-1:0] bit_rev(input logic [REV_MAX-1:0] v, input int width);
        logic [REV_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAX; i++) begin
            if (i < width) begin
                r[i] = v[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_share_pipe.sv
// rtl/cnt_share_pipe.sv - one bank's PDEP-deep (value, valid) shift pipeline
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_val, in_vld      sample entering the bank
//   out_val, out_vld    sample leaving the last stage
// A stage only loads a new value when its incoming valid is set, so the
// output keeps the last valid value while bubbles pass through.
module cnt_share_pipe #(
    parameter int CWID = 8,
    parameter int PDEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CWID-1:0] in_val,
    input  logic            in_vld,
    output logic [CWID-1:0] out_val,
    output logic            out_vld
);

    logic [CWID-1:0] val_q [PDEP];
    logic [PDEP-1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PDEP; i++) begin
                val_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                val_q[0] <= in_val;
            end
            for (int i = 1; i < PDEP; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    val_q[i] <= val_q[i-1];
                end
            end
        end
    end

    assign out_val = val_q[PDEP-1];
    assign out_vld = vld_q[PDEP-1];

endmodule

// File: rtl/cnt_share_seq_gen.sv
// rtl/cnt_share_seq_gen.sv - shared-counter sequence generator fanned out to BDIM banks of SDIM lanes
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        run request pulse, accepted only in IDLE with len != 0
//   len          samples per run, latched at start
//   mode         0 binary count, 1 bit-reversed count, latched at start
//   hold         (only with CNT_SHARE_HOLD_EN) stall issue in RUN, bubble enters banks
//   busy         run in progress, from the first issue through the done cycle
//   done         one-cycle pulse with the final valid sample on seqOut
//   seqVld       per-bank sample valid
//   seqOut       lane values, lane b*SDIM+j carries bank b (CWID bits per lane)
// Optional macro: CNT_SHARE_HOLD_EN adds the hold input.
module cnt_share_seq_gen
    import cnt_share_pkg::*;
#(
    parameter int CWID = 8,
    parameter int BDIM = 16,
    parameter int SDIM = 32,
    parameter int PDEP = 1,
    parameter int LWID = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LWID-1:0]           len,
    input  logic                      mode,
`ifdef CNT_SHARE_HOLD_EN
    input  logic                      hold,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [BDIM-1:0]           seqVld,
    output logic [BDIM*SDIM*CWID-1:0] seqOut
);

    localparam int DWID = $clog2(PDEP + 1) + 1;

    state_t          state;
    state_t          state_nx;
    logic [CWID-1:0] r_q;
    logic [LWID-1:0] left_q;
    logic            mode_q;
    logic [DWID-1:0] drn_q;
    logic            busy_q;
    logic [CWID-1:0] src_val;
    logic            src_vld;
    logic [CWID-1:0] rev_val;
    logic            hold_w;
    logic            issue;
    logic            last_drain;

`ifdef CNT_SHARE_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign issue      = (state == ST_RUN) && !hold_w;
    // The final sample leaves the last stage PDEP edges after it was issued,
    // which is the DRAIN cycle where the drain count reaches PDEP.
    assign last_drain = (state == ST_DRAIN) && (drn_q == DWID'(PDEP));
    assign rev_val    = CWID'(bit_rev(32'(r_q), CWID));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (left_q == LWID'(1))) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                done = last_drain;
                if (last_drain) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            left_q  <= '0;
            mode_q  <= MODE_BIN;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            src_val <= '0;
            src_vld <= 1'b0;
        end else begin
            // busy rises at the first issue edge, not the start edge, and
            // falls at the edge that returns the FSM to IDLE.
            busy_q  <= (state != ST_IDLE) && (state_nx != ST_IDLE);
            src_vld <= issue;
            if ((state == ST_IDLE) && (state_nx == ST_RUN)) begin
                left_q <= len;
                mode_q <= mode;
                r_q    <= '0;
            end
            if (issue) begin
                r_q     <= r_q + 1'b1;
                left_q  <= left_q - 1'b1;
                src_val <= (mode_q == MODE_REV) ? rev_val : r_q;
            end
            if (state == ST_DRAIN) begin
                drn_q <= drn_q + 1'b1;
            end else begin
                drn_q <= '0;
            end
        end
    end

    assign busy = busy_q;

    logic [CWID-1:0] bank_val [BDIM];

    for (genvar b = 0; b < BDIM; b++) begin : g_bank
        cnt_share_pipe #(
            .CWID(CWID),
            .PDEP(PDEP)
        ) u_pipe (
            .clk    (clk),
            .rst_n  (rst_n),
            .in_val (src_val),
            .in_vld (src_vld),
            .out_val(bank_val[b]),
            .out_vld(seqVld[b])
        );
        for (genvar j = 0; j < SDIM; j++) begin : g_lane
            assign seqOut[(b*SDIM + j)*CWID +: CWID] = bank_val[b];
        end
    end

endmodule

// File: tb/tb_cnt_share_seq_gen.sv
// tb/tb_cnt_share_seq_gen.sv - randomized self-checking bench for cnt_share_seq_gen
module tb_cnt_share_seq_gen;

    localparam int CW = 3;
    localparam int BD = 3;
    localparam int SD = 2;
    localparam int PD = 3;
    localparam int LW = 6;
    localparam int KMAX = 120;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [LW-1:0]         len;
    logic                  mode;
`ifdef CNT_SHARE_HOLD_EN
    logic                  hold;
`endif
    logic                  busy;
    logic                  done;
    logic [BD-1:0]         seqVld;
    logic [BD*SD*CW-1:0]   seqOut;

    int            n_tests;
    int            n_fail;
    logic [CW-1:0] exp_last;
    logic          ivld [0:KMAX];
    logic [CW-1:0] ival [0:KMAX];

    cnt_share_seq_gen #(
        .CWID(CW),
        .BDIM(BD),
        .SDIM(SD),
        .PDEP(PD),
        .LWID(LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .mode  (mode),
`ifdef CNT_SHARE_HOLD_EN
        .hold  (hold),
`endif
        .busy  (busy),
        .done  (done),
        .seqVld(seqVld),
        .seqOut(seqOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample v of a run: v counts modulo 2^CW, mode 1 mirrors the digits.
    function automatic logic [CW-1:0] ref_val(input int v, input int m);
        int x;
        int rev;
        x = v % (1 << CW);
        if (m == 0) return CW'(x);
        rev = 0;
        for (int i = 0; i < CW; i++) begin
            rev = rev * 2 + (x % 2);
            x   = x / 2;
        end
        return CW'(rev);
    endfunction

    function automatic logic [BD*SD*CW-1:0] lanes_of(input logic [CW-1:0] v);
        logic [BD*SD*CW-1:0] r;
        for (int l = 0; l < BD*SD; l++) r[l*CW +: CW] = v;
        return r;
    endfunction

    task automatic do_run(input int L, input int m, input bit stray,
                          input bit hold_rand, input logic [63:0] hold_mask, input string tag);
        int   issued;
        int   end_k;
        int   kk;
        bit   finished;
        logic h;
        logic [BD-1:0] ev;
        issued   = 0;
        end_k    = -1;
        finished = 0;
        @(negedge clk);
        start = 1'b1;
        len   = LW'(L);
        mode  = m[0];
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_edge busy/done got %b%b exp 00", tag, busy, done);
        end
        for (int k = 1; k < KMAX && !finished; k++) begin
            @(negedge clk);
            start = (stray && (end_k < 0 || k <= end_k + 1)) ? 1'($urandom) : 1'b0;
            len   = LW'($urandom);
            mode  = 1'($urandom);
            h = hold_rand ? 1'($urandom % 3 == 0) : ((k < 64) ? hold_mask[k] : 1'b0);
`ifdef CNT_SHARE_HOLD_EN
            hold = h;
`else
            h = 1'b0;
`endif
            ivld[k] = 1'b0;
            if (issued < L && !h) begin
                ivld[k] = 1'b1;
                ival[k] = ref_val(issued, m);
                issued++;
                if (issued == L) end_k = k + PD;
            end
            @(posedge clk);
            #1;
            kk = k - PD;
            ev = '0;
            if (kk >= 1 && ivld[kk]) begin
                ev       = '1;
                exp_last = ival[kk];
            end
            n_tests += 4;
            if (seqVld !== ev) begin
                n_fail++;
                $display("FAIL %s k=%0d seqVld got %b exp %b", tag, k, seqVld, ev);
            end
            if (seqOut !== lanes_of(exp_last)) begin
                n_fail++;
                $display("FAIL %s k=%0d seqOut got %h exp %h", tag, k, seqOut, lanes_of(exp_last));
            end
            if (busy !== (end_k < 0 || k <= end_k)) begin
                n_fail++;
                $display("FAIL %s k=%0d busy got %b exp %b", tag, k, busy, (end_k < 0 || k <= end_k));
            end
            if (done !== (k == end_k)) begin
                n_fail++;
                $display("FAIL %s k=%0d done got %b exp %b", tag, k, done, (k == end_k));
            end
            if (end_k >= 0 && k == end_k + 2) finished = 1;
        end
        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout got no end of run exp end within %0d cycles", tag, KMAX);
        end
        start = 1'b0;
`ifdef CNT_SHARE_HOLD_EN
        hold = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        mode  = 1'b0;
`ifdef CNT_SHARE_HOLD_EN
        hold  = 1'b0;
`endif
        exp_last = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, seqVld, seqOut} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got %b%b %b %h exp all zero", busy, done, seqVld, seqOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bin_count();
        do_run(4, 0, 0, 0, 64'd0, "bin4");
    endtask

    task automatic test_bitrev();
        do_run(8, 1, 0, 0, 64'd0, "rev8");
    endtask

    task automatic test_wrap();
        do_run(10, 0, 0, 0, 64'd0, "wrap10");
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || seqVld !== '0 || seqOut !== lanes_of(exp_last)) begin
                n_fail++;
                $display("FAIL len0 k=%0d busy/done/vld got %b%b%b exp 000", k, busy, done, seqVld);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_stray_start();
        do_run(8, 1, 1, 0, 64'd0, "stray");
        do_run(1, 0, 1, 0, 64'd0, "len1");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        start = 1'b1;
        len   = LW'(6);
        mode  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b1 || seqVld !== '1 || seqOut !== lanes_of(CW'(1))) begin
            n_fail++;
            $display("FAIL abort_pre got busy %b vld %b out %h exp 1 %b %h",
                     busy, seqVld, seqOut, {BD{1'b1}}, lanes_of(CW'(1)));
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, seqVld, seqOut} !== '0) begin
            n_fail++;
            $display("FAIL abort_now got %b%b %b %h exp all zero", busy, done, seqVld, seqOut);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold k=%0d busy/done got %b%b exp 00", k, busy, done);
            end
        end
        @(negedge clk);
        rst_n    = 1'b1;
        exp_last = '0;
        do_run(6, 0, 0, 0, 64'd0, "after_abort");
    endtask

    task automatic test_back_to_back();
        do_run(3, 1, 0, 0, 64'd0, "b2b_a");
        do_run(5, 0, 0, 0, 64'd0, "b2b_b");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            do_run($urandom_range(1, 20), int'($urandom % 2), 1, 1, 64'd0, "rand");
        end
    endtask

`ifdef CNT_SHARE_HOLD_EN
    task automatic test_hold();
        do_run(4, 0, 0, 0, 64'b1100, "hold");
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_bin_count();
        test_bitrev();
        test_wrap();
        test_len_zero();
        test_stray_start();
        test_reset_abort();
        test_back_to_back();
`ifdef CNT_SHARE_HOLD_EN
        test_hold();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
